pipelined_wallace_multiplier: RTL and testbench

Parametrised, pipelined Wallace-tree multiplier with a valid/ready handshake and per-transaction signed/unsigned selection. It generalises the fixed 4×4 combinational Wallace multiplier to any `Width` and supports back-pressure. It registers operands, reduces partial products with a carry-save tree to two rows, and resolves them with a final carry-propagate add. It sits in the filter datapath between coefficient/sample sources and the accumulation stage.

---
 rtl/multiplier_pkg.sv | 36 +++
 rtl/adder.sv | 13 +
 rtl/csa_row_reduce.sv | 62 ++++++
 rtl/full_adder.sv | 14 +
 rtl/half_adder.sv | 13 +
 rtl/pipelined_wallace_multiplier.sv | 151 +++++++++++++++
 tb/tb_pipelined_wallace_multiplier.sv | 306 ++++++++++++++++++++++++++++++
 7 files changed

// File: rtl/multiplier_pkg.sv
// Shared types and elaboration-time helpers for the pipelined Wallace multiplier.
// Row-count helpers size the carry-save tree levels.
package multiplier_pkg;

    typedef enum logic {
        MultUnsigned = 1'b0,
        MultSigned   = 1'b1
    } mult_mode_e;

    // One level turns every group of three rows into two; leftover rows keep their count.
    function automatic int reduce_rows(int rows);
        return 2 * (rows / 3) + rows % 3;
    endfunction

    function automatic int rows_at_level(int rows, int level);
        int r;
        r = rows;
        for (int i = 0; i < level; i++) begin
            r = reduce_rows(r);
        end
        return r;
    endfunction

    function automatic int wallace_levels(int rows);
        int r;
        int n;
        r = rows;
        n = 0;
        while (r > 2) begin
            r = reduce_rows(r);
            n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/adder.sv
// Modular carry-propagate adder, sum wraps at 2^Width.
// Purely combinational, no flow control.
module adder #(
    parameter int Width = 8
) (
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    output logic [Width-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/csa_row_reduce.sv
// One Wallace level: rows in groups of three go through full adders, a leftover pair through
// half adders, a single leftover row passes straight through. Combinational, no flow control.
module csa_row_reduce
    import multiplier_pkg::*;
#(
    parameter int Width   = 8,
    parameter int InRows  = 3,
    parameter int OutRows = reduce_rows(InRows)
) (
    input  logic [InRows*2*Width-1:0]  rows_i,
    output logic [OutRows*2*Width-1:0] rows_o
);

    localparam int Cols   = 2 * Width;
    localparam int Groups = InRows / 3;
    localparam int Rem    = InRows % 3;

    for (genvar g = 0; g < Groups; g++) begin : g_fa
        localparam int Ia = (3 * g) * Cols;
        localparam int Ib = (3 * g + 1) * Cols;
        localparam int Ic = (3 * g + 2) * Cols;
        localparam int Os = (2 * g) * Cols;
        localparam int Oc = (2 * g + 1) * Cols;

        for (genvar b = 0; b < Cols - 1; b++) begin : g_col
            full_adder u_fa (
                .a_i    (rows_i[Ia + b]),
                .b_i    (rows_i[Ib + b]),
                .c_i    (rows_i[Ic + b]),
                .sum_o  (rows_o[Os + b]),
                .carry_o(rows_o[Oc + b + 1])
            );
        end

        // The product is taken modulo 2^Cols, so the top column only needs its sum bit.
        assign rows_o[Os + Cols - 1] = rows_i[Ia + Cols - 1] ^ rows_i[Ib + Cols - 1]
                                     ^ rows_i[Ic + Cols - 1];
        assign rows_o[Oc] = 1'b0;
    end

    if (Rem == 2) begin : g_ha
        localparam int Ia = (3 * Groups) * Cols;
        localparam int Ib = (3 * Groups + 1) * Cols;
        localparam int Os = (2 * Groups) * Cols;
        localparam int Oc = (2 * Groups + 1) * Cols;

        for (genvar b = 0; b < Cols - 1; b++) begin : g_col
            half_adder u_ha (
                .a_i    (rows_i[Ia + b]),
                .b_i    (rows_i[Ib + b]),
                .sum_o  (rows_o[Os + b]),
                .carry_o(rows_o[Oc + b + 1])
            );
        end

        assign rows_o[Os + Cols - 1] = rows_i[Ia + Cols - 1] ^ rows_i[Ib + Cols - 1];
        assign rows_o[Oc] = 1'b0;
    end else if (Rem == 1) begin : g_pass
        assign rows_o[2 * Groups * Cols +: Cols] = rows_i[3 * Groups * Cols +: Cols];
    end

endmodule

// File: rtl/full_adder.sv
// 3:2 counter cell used in the carry-save tree.
// Purely combinational, no flow control.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic sum_o,
    output logic carry_o
);

    assign sum_o   = a_i ^ b_i ^ c_i;
    assign carry_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/half_adder.sv
// 2:2 counter cell used in the carry-save tree.
// Purely combinational, no flow control.
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);

    assign sum_o   = a_i ^ b_i;
    assign carry_o = a_i & b_i;

endmodule

// File: rtl/pipelined_wallace_multiplier.sv
// Three-stage signed/unsigned Wallace multiplier: operands -> carry-save rows -> product.
// Every stage advances only when S3 is empty or being drained; in_ready drops in the same cycle.
module pipelined_wallace_multiplier
    import multiplier_pkg::*;
#(
    parameter int Width = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic               signed_i,
    input  logic [Width-1:0]   data_in1_i,
    input  logic [Width-1:0]   data_in2_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [2*Width-1:0] data_out_o
);

    localparam int Cols   = 2 * Width;
    localparam int PpRows = Width + 1;
    localparam int Levels = wallace_levels(PpRows);

    logic               en;

    logic               s1_vld_q, s1_vld_d;
    logic [Width-1:0]   s1_a_q, s1_a_d;
    logic [Width-1:0]   s1_b_q, s1_b_d;
    mult_mode_e         s1_mode_q, s1_mode_d;

    logic               s2_vld_q, s2_vld_d;
    logic [Cols-1:0]    s2_sum_q, s2_sum_d;
    logic [Cols-1:0]    s2_carry_q, s2_carry_d;

    logic               s3_vld_q, s3_vld_d;
    logic [Cols-1:0]    s3_dat_q, s3_dat_d;

    logic [PpRows*Cols-1:0] pp_rows;
    logic [2*Cols-1:0]      tree_rows;
    logic [Cols-1:0]        final_sum;

    assign en          = ~s3_vld_q | out_ready_i;
    assign in_ready_o  = en;
    assign out_valid_o = s3_vld_q;
    assign data_out_o  = s3_dat_q;

    // Baugh-Wooley: invert the MSB row and column (not their shared corner) and add a
    // constant row with ones at columns Width and 2*Width-1; all of it gated by the mode.
    always_comb begin
        pp_rows = '0;
        for (int i = 0; i < Width; i++) begin
            for (int j = 0; j < Width; j++) begin
                pp_rows[i * Cols + i + j] = (s1_a_q[j] & s1_b_q[i])
                    ^ ((s1_mode_q == MultSigned) && ((i == Width - 1) != (j == Width - 1)));
            end
        end
        if (s1_mode_q == MultSigned) begin
            pp_rows[Width * Cols + Width]    = 1'b1;
            pp_rows[Width * Cols + Cols - 1] = 1'b1;
        end
    end

    for (genvar k = 0; k < Levels; k++) begin : g_lvl
        localparam int InRows  = rows_at_level(PpRows, k);
        localparam int OutRows = rows_at_level(PpRows, k + 1);

        logic [InRows*Cols-1:0]  rows_in;
        logic [OutRows*Cols-1:0] rows_out;

        if (k == 0) begin : g_src
            assign rows_in = pp_rows;
        end else begin : g_src
            assign rows_in = g_lvl[k-1].rows_out;
        end

        csa_row_reduce #(
            .Width  (Width),
            .InRows (InRows),
            .OutRows(OutRows)
        ) u_csa (
            .rows_i(rows_in),
            .rows_o(rows_out)
        );
    end

    assign tree_rows = g_lvl[Levels-1].rows_out;

    adder #(
        .Width(Cols)
    ) u_final_add (
        .a_i  (s2_sum_q),
        .b_i  (s2_carry_q),
        .sum_o(final_sum)
    );

    always_comb begin
        s1_vld_d   = s1_vld_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_mode_d  = s1_mode_q;
        s2_vld_d   = s2_vld_q;
        s2_sum_d   = s2_sum_q;
        s2_carry_d = s2_carry_q;
        s3_vld_d   = s3_vld_q;
        s3_dat_d   = s3_dat_q;

        if (en) begin
            s1_vld_d = in_valid_i;
            s2_vld_d = s1_vld_q;
            s3_vld_d = s2_vld_q;
            // Data registers only load behind a valid bit, so bubbles leave the last result in place.
            if (in_valid_i) begin
                s1_a_d    = data_in1_i;
                s1_b_d    = data_in2_i;
                s1_mode_d = signed_i ? MultSigned : MultUnsigned;
            end
            if (s1_vld_q) begin
                s2_sum_d   = tree_rows[Cols-1:0];
                s2_carry_d = tree_rows[2*Cols-1:Cols];
            end
            if (s2_vld_q) begin
                s3_dat_d = final_sum;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_vld_q   <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_mode_q  <= MultUnsigned;
            s2_vld_q   <= 1'b0;
            s2_sum_q   <= '0;
            s2_carry_q <= '0;
            s3_vld_q   <= 1'b0;
            s3_dat_q   <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_mode_q  <= s1_mode_d;
            s2_vld_q   <= s2_vld_d;
            s2_sum_q   <= s2_sum_d;
            s2_carry_q <= s2_carry_d;
            s3_vld_q   <= s3_vld_d;
            s3_dat_q   <= s3_dat_d;
        end
    end

endmodule

// File: tb/tb_pipelined_wallace_multiplier.sv
// Bench for pipelined_wallace_multiplier: directed corners on an 8-bit instance plus
// random/exhaustive sweeps on 2-, 4- and 16-bit instances against an arithmetic model.
module tb_pipelined_wallace_multiplier;

    localparam int SweepN = 10000;

    logic        clk_i;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        signed_i;
    logic [7:0]  data_in1_i;
    logic [7:0]  data_in2_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] data_out_o;

    logic        sweep_rst;
    logic        sweep_go;

    int          n_tests;
    int          n_fail;
    int          out_cnt;
    logic        prev_stall;
    logic [15:0] prev_dat;
    logic [63:0] exp_q[$];

    pipelined_wallace_multiplier #(
        .Width(8)
    ) u_dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .signed_i   (signed_i),
        .data_in1_i (data_in1_i),
        .data_in2_i (data_in2_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .data_out_o (data_out_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Exact product of two w-bit operands, reduced to 2*w bits.
    function automatic logic [63:0] ref_product(input int w, input logic [31:0] a,
                                                input logic [31:0] b, input logic s);
        logic [63:0] mask;
        logic [63:0] ea;
        logic [63:0] eb;
        mask = (64'd1 << w) - 64'd1;
        ea   = {32'd0, a} & mask;
        eb   = {32'd0, b} & mask;
        if (s && ea[w-1]) ea = ea | ~mask;
        if (s && eb[w-1]) eb = eb | ~mask;
        return (ea * eb) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // Sampled mid-cycle: the values seen here are the ones the next rising edge acts on.
    always @(negedge clk_i) begin
        if (rst_i) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid_o), 64'd1);
                check("hold_data", 64'(data_out_o), 64'(prev_dat));
            end
            if (out_valid_o && !out_ready_i) begin
                check("in_ready_stall", 64'(in_ready_o), 64'd0);
            end
            if (out_valid_o && out_ready_i) begin
                check("result_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    check("result", 64'(data_out_o), exp_q.pop_front());
                end
                out_cnt++;
            end
            if (in_valid_i && in_ready_o) begin
                exp_q.push_back(ref_product(8, 32'(data_in1_i), 32'(data_in2_i), signed_i));
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_dat   = data_out_o;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
        localparam int W = (gi == 0) ? 2 : ((gi == 1) ? 4 : 16);

        logic           sw_in_valid;
        logic           sw_in_ready;
        logic           sw_signed;
        logic           sw_out_valid;
        logic [W-1:0]   sw_a;
        logic [W-1:0]   sw_b;
        logic [2*W-1:0] sw_dout;
        logic [63:0]    sw_q[$];
        logic           done;

        pipelined_wallace_multiplier #(
            .Width(W)
        ) u_dut (
            .clk_i      (clk_i),
            .rst_i      (sweep_rst),
            .in_valid_i (sw_in_valid),
            .in_ready_o (sw_in_ready),
            .signed_i   (sw_signed),
            .data_in1_i (sw_a),
            .data_in2_i (sw_b),
            .out_valid_o(sw_out_valid),
            .out_ready_i(1'b1),
            .data_out_o (sw_dout)
        );

        initial begin
            done        = 1'b0;
            sw_in_valid = 1'b0;
            sw_signed   = 1'b0;
            sw_a        = '0;
            sw_b        = '0;
            wait (sweep_go);
            @(posedge clk_i);
            #1;
            for (int n = 0; n < SweepN; n++) begin
                if (W == 4 && n < 512) begin
                    sw_signed = n[8];
                    sw_a      = W'(n >> 4);
                    sw_b      = W'(n);
                end else begin
                    sw_signed = 1'($urandom());
                    sw_a      = W'($urandom());
                    sw_b      = W'($urandom());
                end
                sw_in_valid = 1'b1;
                @(posedge clk_i);
                #1;
            end
            sw_in_valid = 1'b0;
            repeat (6) @(posedge clk_i);
            #1;
            check($sformatf("w%0d_drained", W), 64'(sw_q.size()), 64'd0);
            done = 1'b1;
        end

        always @(negedge clk_i) begin
            if (!sweep_rst) begin
                if (sw_out_valid) begin
                    check($sformatf("w%0d_expected", W), 64'(sw_q.size() != 0), 64'd1);
                    if (sw_q.size() != 0) begin
                        check($sformatf("w%0d_result", W), 64'(sw_dout), sw_q.pop_front());
                    end
                end
                if (sw_in_valid && sw_in_ready) begin
                    sw_q.push_back(ref_product(W, 32'(sw_a), 32'(sw_b), sw_signed));
                end
            end
        end
    end

    // Operands are held until the rising edge that accepts them; returns just after that edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic acc;
        acc        = 1'b0;
        in_valid_i = 1'b1;
        data_in1_i = a;
        data_in2_i = b;
        signed_i   = s;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk_i);
            acc = in_ready_o;
            @(posedge clk_i);
            #1;
        end
        check("send_accepted", 64'(acc), 64'd1);
    endtask

    // Operands presented in cycle 0 are accepted at the closing edge; the result is valid in cycle 3.
    task automatic run_vec(input logic [7:0] a, input logic [7:0] b, input logic s,
                           input logic [15:0] exp);
        send(a, b, s);
        in_valid_i = 1'b0;
        check("lat_c1_valid", 64'(out_valid_o), 64'd0);
        @(posedge clk_i);
        #1;
        check("lat_c2_valid", 64'(out_valid_o), 64'd0);
        @(posedge clk_i);
        #1;
        check("lat_c3_valid", 64'(out_valid_o), 64'd1);
        check($sformatf("dir_%0h_x_%0h_s%0d", a, b, s), 64'(data_out_o), 64'(exp));
    endtask

    logic [7:0]  va[8];
    logic [7:0]  vb[8];
    logic        vs[8];
    logic [15:0] ve[8];
    logic        bp_done;
    int          base_cnt;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        out_cnt     = 0;
        prev_stall  = 1'b0;
        prev_dat    = '0;
        rst_i       = 1'b1;
        sweep_rst   = 1'b1;
        sweep_go    = 1'b0;
        in_valid_i  = 1'b0;
        signed_i    = 1'b0;
        data_in1_i  = '0;
        data_in2_i  = '0;
        out_ready_i = 1'b1;
        bp_done     = 1'b0;

        va = '{8'hFF, 8'h00, 8'h01, 8'h80, 8'hFF, 8'h7F, 8'h80, 8'hFF};
        vb = '{8'hFF, 8'hAD, 8'hC8, 8'h80, 8'h01, 8'h80, 8'h80, 8'h01};
        vs = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0};
        ve = '{16'hFE01, 16'h0000, 16'h00C8, 16'h4000, 16'hFFFF, 16'hC080, 16'h4000, 16'h00FF};

        repeat (2) @(posedge clk_i);
        #1;
        rst_i     = 1'b0;
        sweep_rst = 1'b0;
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_data_out", 64'(data_out_o), 64'd0);
        check("rst_in_ready", 64'(in_ready_o), 64'd1);

        for (int i = 0; i < 8; i++) begin
            run_vec(va[i], vb[i], vs[i], ve[i]);
        end
        @(posedge clk_i);
        #1;

        // Back-to-back stream under random back-pressure.
        base_cnt = out_cnt;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send(8'(17 * i + 3), 8'(250 - 13 * i), 1'(i));
                end
                in_valid_i = 1'b0;
                bp_done    = 1'b1;
            end
            begin
                while (!bp_done) begin
                    out_ready_i = 1'($urandom_range(0, 1));
                    @(posedge clk_i);
                    #1;
                end
                out_ready_i = 1'b1;
            end
        join
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) begin
            @(posedge clk_i);
            #1;
        end
        @(posedge clk_i);
        #1;
        check("bp_count", 64'(out_cnt - base_cnt), 64'd10);
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Reset with three transactions in flight.
        send(8'd9, 8'd9, 1'b0);
        send(8'd10, 8'd11, 1'b1);
        send(8'd12, 8'd13, 1'b0);
        in_valid_i = 1'b0;
        rst_i      = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("rst_flush_valid", 64'(out_valid_o), 64'd0);
            @(posedge clk_i);
            #1;
        end
        run_vec(8'd5, 8'd6, 1'b0, 16'h001E);
        @(posedge clk_i);
        #1;

        sweep_go = 1'b1;
        for (int c = 0; c < 15000 && !(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done); c++) begin
            @(posedge clk_i);
        end
        #1;
        check("sweep_done", 64'(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
